// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing the async FIFO write port (write-clock domain).
// Optional per-requester accepted-beat statistics are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic                                 fifo_full,
   output logic                                 fifo_wr_en,
   output logic [DATA_WIDTH-1:0]                fifo_wr_data,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
   output logic                                 busy,
   input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] stat_sel,
   input  logic                                 stat_clr,
   output logic [7:0]                           stat_count
);

   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       owner_q, owner_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

   logic                  pick_vld;
   logic [ID_W-1:0]       pick_idx;
   logic                  owner_vld;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  xfer;

   // Walk offsets from the highest down so the nearest requester at or after rr_ptr wins.
   always_comb begin : rr_pick
      int idx;
      idx      = 0;
      pick_vld = 1'b0;
      pick_idx = rr_ptr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (req_valid[ID_W'(idx)]) begin
            pick_vld = 1'b1;
            pick_idx = ID_W'(idx);
         end
      end
   end

   always_comb begin : owner_mux
      owner_vld  = 1'b0;
      owner_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == ID_W'(i)) begin
            owner_vld  = req_valid[i];
            owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign xfer     = (state_q == BURST) && owner_vld && !fifo_full;
   assign grant_id = owner_q;

   always_comb begin : fsm_next
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      busy         = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               owner_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            busy               = 1'b1;
            req_ready[owner_q] = !fifo_full;
            fifo_wr_en         = xfer;
            fifo_wr_data       = owner_data;
            // A full FIFO freezes the burst: no beat counted and a dropped valid is ignored.
            if (xfer) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d    = IDLE;
                  beat_cnt_d = '0;
                  rr_ptr_d   = ID_W'((int'(owner_q) + 1) % NUM_REQ);
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end else if (!fifo_full && !owner_vld) begin
               state_d    = IDLE;
               beat_cnt_d = '0;
               rr_ptr_d   = ID_W'((int'(owner_q) + 1) % NUM_REQ);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [7:0] stat_cnt_q [NUM_REQ];
   logic [7:0] stat_count_p1;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Clear takes priority over a same-cycle beat and also blanks the registered read-out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) stat_cnt_q[i] <= '0;
         stat_count_p1 <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_clr)
               stat_cnt_q[i] <= '0;
            else if (xfer && (owner_q == ID_W'(i)))
               stat_cnt_q[i] <= sat_inc(stat_cnt_q[i]);
         end
         if (stat_clr || (int'(stat_sel) >= NUM_REQ))
            stat_count_p1 <= '0;
         else
            stat_count_p1 <= stat_cnt_q[stat_sel];
      end
   end

   assign stat_count = stat_count_p1;
`else
   logic unused_stat;
   assign unused_stat = ^{stat_sel, stat_clr};
   assign stat_count  = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-scenario cycle checks plus a beat scoreboard on the FIFO port.
module tb_fifo_wr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [3:0]  fifo_wr_data;
   logic [1:0]  grant_id;
   logic        busy;
   logic [1:0]  stat_sel;
   logic        stat_clr;
   logic [7:0]  stat_count;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] data;
   } beat_t;
   beat_t exp_q[$];

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .BURST_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
      .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy),
      .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_count(stat_count)
   );

   // Scoreboard: every FIFO write must match the next expected beat.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n && fifo_wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_beat got id=%0d data=%h", grant_id, fifo_wr_data);
         end else begin
            e = exp_q.pop_front();
            if (grant_id !== e.id || fifo_wr_data !== e.data || req_ready !== (4'b0001 << e.id)) begin
               failures++;
               $display("FAIL sb_beat got id=%0d data=%h ready=%b exp id=%0d data=%h",
                        grant_id, fifo_wr_data, req_ready, e.id, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      stat_sel  = '0;
      stat_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_data  = 16'hFFFF;
      fifo_full = 1'b0;
      stat_sel  = 2'd1;
      stat_clr  = 1'b0;
      repeat (2) @(negedge clk);
      obs = {busy, fifo_wr_en, grant_id, req_ready};
      checks++;
      if (obs !== 8'h00 || fifo_wr_data !== 4'h0 || stat_count !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs got ctl=%b data=%h stat=%h exp 0", obs, fifo_wr_data, stat_count);
      end
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      obs = {busy, fifo_wr_en, grant_id, req_ready};
      checks++;
      if (obs !== 8'h00) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=%b", obs, 8'h00);
      end
   endtask

   task automatic test_single_req();
      logic [7:0] obs;
      logic [7:0] exp [11];
      do_reset();
      exp = '{{1'b0,1'b0,2'd0,4'b0000},
              {1'b1,1'b1,2'd2,4'b0100}, {1'b1,1'b1,2'd2,4'b0100},
              {1'b1,1'b1,2'd2,4'b0100}, {1'b1,1'b1,2'd2,4'b0100},
              {1'b0,1'b0,2'd2,4'b0000},
              {1'b1,1'b0,2'd2,4'b0100},
              {1'b0,1'b0,2'd2,4'b0000},
              {1'b1,1'b1,2'd3,4'b1000},
              {1'b1,1'b0,2'd3,4'b1000},
              {1'b0,1'b0,2'd3,4'b0000}};
      for (int c = 0; c < 11; c++) begin
         tick();
         case (c)
            0: begin
               req_valid = 4'b0100;
               req_data[8 +: 4] = 4'h5;
               repeat (4) exp_q.push_back('{id: 2'd2, data: 4'h5});
            end
            6: req_valid = 4'b0000;
            7: begin
               req_valid = 4'b1001;
               req_data[0 +: 4]  = 4'h1;
               req_data[12 +: 4] = 4'h3;
               exp_q.push_back('{id: 2'd3, data: 4'h3});
            end
            9: req_valid = 4'b0000;
            default: ;
         endcase
         @(negedge clk);
         obs = {busy, fifo_wr_en, grant_id, req_ready};
         checks++;
         if (obs !== exp[c]) begin
            failures++;
            $display("FAIL single_req cycle=%0d got=%b exp=%b", c, obs, exp[c]);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] obs;
      logic [7:0] e;
      logic [1:0] order [5];
      logic [1:0] prev;
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      tick();
      req_valid = 4'b1111;
      req_data  = 16'hBA98;
      for (int b = 0; b < 5; b++)
         repeat (4) exp_q.push_back('{id: order[b], data: 4'(8 + int'(order[b]))});
      prev = 2'd0;
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         e   = {1'b0, 1'b0, prev, 4'b0000};
         obs = {busy, fifo_wr_en, grant_id, req_ready};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL rr_gap burst=%0d got=%b exp=%b", b, obs, e);
         end
         for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            e   = {1'b1, 1'b1, order[b], 4'b0001 << order[b]};
            obs = {busy, fifo_wr_en, grant_id, req_ready};
            checks++;
            if (obs !== e) begin
               failures++;
               $display("FAIL rr_burst burst=%0d beat=%0d got=%b exp=%b", b, k, obs, e);
            end
         end
         prev = order[b];
         tick();
      end
      req_valid = 4'b0000;
      @(negedge clk);
      obs = {busy, fifo_wr_en, grant_id, req_ready};
      checks++;
      if (obs !== {1'b0, 1'b0, 2'd0, 4'b0000}) begin
         failures++;
         $display("FAIL rr_final got=%b exp=%b", obs, 8'h00);
      end
   endtask

   task automatic test_full_stall();
      logic [7:0] obs;
      logic [7:0] exp [9];
      do_reset();
      exp = '{{1'b0,1'b0,2'd0,4'b0000},
              {1'b1,1'b1,2'd1,4'b0010}, {1'b1,1'b1,2'd1,4'b0010},
              {1'b1,1'b0,2'd1,4'b0000}, {1'b1,1'b0,2'd1,4'b0000},
              {1'b1,1'b0,2'd1,4'b0000},
              {1'b1,1'b1,2'd1,4'b0010}, {1'b1,1'b1,2'd1,4'b0010},
              {1'b0,1'b0,2'd1,4'b0000}};
      for (int c = 0; c < 9; c++) begin
         tick();
         case (c)
            0: begin
               req_valid = 4'b0010;
               req_data[4 +: 4] = 4'h1;
               for (int k = 1; k <= 4; k++) exp_q.push_back('{id: 2'd1, data: 4'(k)});
            end
            2: req_data[4 +: 4] = 4'h2;
            3: begin
               req_data[4 +: 4] = 4'h3;
               fifo_full = 1'b1;
            end
            4: req_valid = 4'b0000;
            5: req_valid = 4'b0010;
            6: fifo_full = 1'b0;
            7: req_data[4 +: 4] = 4'h4;
            8: req_valid = 4'b0000;
            default: ;
         endcase
         @(negedge clk);
         obs = {busy, fifo_wr_en, grant_id, req_ready};
         checks++;
         if (obs !== exp[c]) begin
            failures++;
            $display("FAIL full_stall cycle=%0d got=%b exp=%b", c, obs, exp[c]);
         end
      end
   endtask

   task automatic test_owner_drop();
      logic [7:0] obs;
      logic [7:0] exp [10];
      do_reset();
      exp = '{{1'b0,1'b0,2'd0,4'b0000},
              {1'b1,1'b1,2'd0,4'b0001}, {1'b1,1'b1,2'd0,4'b0001},
              {1'b1,1'b0,2'd0,4'b0001},
              {1'b0,1'b0,2'd0,4'b0000},
              {1'b1,1'b1,2'd3,4'b1000}, {1'b1,1'b1,2'd3,4'b1000},
              {1'b1,1'b1,2'd3,4'b1000}, {1'b1,1'b1,2'd3,4'b1000},
              {1'b0,1'b0,2'd3,4'b0000}};
      for (int c = 0; c < 10; c++) begin
         tick();
         case (c)
            0: begin
               req_valid = 4'b1001;
               req_data  = 16'hC006;
               repeat (2) exp_q.push_back('{id: 2'd0, data: 4'h6});
               repeat (4) exp_q.push_back('{id: 2'd3, data: 4'hC});
            end
            3: req_valid = 4'b1000;
            9: req_valid = 4'b0000;
            default: ;
         endcase
         @(negedge clk);
         obs = {busy, fifo_wr_en, grant_id, req_ready};
         checks++;
         if (obs !== exp[c]) begin
            failures++;
            $display("FAIL owner_drop cycle=%0d got=%b exp=%b", c, obs, exp[c]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [7:0] obs;
      logic [7:0] exp [6];
      do_reset();
      exp = '{{1'b0,1'b0,2'd0,4'b0000},
              {1'b1,1'b1,2'd1,4'b0010},
              {1'b1,1'b0,2'd1,4'b0010},
              {1'b0,1'b0,2'd1,4'b0000},
              {1'b1,1'b1,2'd2,4'b0100}, {1'b1,1'b1,2'd2,4'b0100}};
      for (int c = 0; c < 6; c++) begin
         tick();
         case (c)
            0: begin
               req_valid = 4'b0010;
               req_data[4 +: 4] = 4'h1;
               exp_q.push_back('{id: 2'd1, data: 4'h1});
            end
            2: begin
               req_valid = 4'b0100;
               req_data[8 +: 4] = 4'h7;
               repeat (2) exp_q.push_back('{id: 2'd2, data: 4'h7});
            end
            default: ;
         endcase
         @(negedge clk);
         obs = {busy, fifo_wr_en, grant_id, req_ready};
         checks++;
         if (obs !== exp[c]) begin
            failures++;
            $display("FAIL rst_mid cycle=%0d got=%b exp=%b", c, obs, exp[c]);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      obs = {busy, fifo_wr_en, grant_id, req_ready};
      checks++;
      if (obs !== 8'h00 || fifo_wr_data !== 4'h0 || stat_count !== 8'h00) begin
         failures++;
         $display("FAIL rst_async got ctl=%b data=%h stat=%h exp 0", obs, fifo_wr_data, stat_count);
      end
      req_valid = 4'b0101;
      req_data[0 +: 4] = 4'hE;
      tick();
      obs = {busy, fifo_wr_en, grant_id, req_ready};
      checks++;
      if (obs !== 8'h00) begin
         failures++;
         $display("FAIL rst_held got=%b exp=%b", obs, 8'h00);
      end
      rst_n = 1'b1;
      repeat (4) exp_q.push_back('{id: 2'd0, data: 4'hE});
      @(negedge clk);
      obs = {busy, fifo_wr_en, grant_id, req_ready};
      checks++;
      if (obs !== 8'h00) begin
         failures++;
         $display("FAIL rst_release_idle got=%b exp=%b", obs, 8'h00);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk);
         obs = {busy, fifo_wr_en, grant_id, req_ready};
         checks++;
         if (obs !== {1'b1, 1'b1, 2'd0, 4'b0001}) begin
            failures++;
            $display("FAIL rst_regrant beat=%0d got=%b exp=%b", k, obs, {1'b1, 1'b1, 2'd0, 4'b0001});
         end
      end
      tick();
      req_valid = 4'b0000;
   endtask

   task automatic test_stats();
      int n;
      n = 0;
      do_reset();
      tick();
      req_valid = 4'b0010;
      req_data[4 +: 4] = 4'h9;
      stat_sel = 2'd1;
      repeat (300) exp_q.push_back('{id: 2'd1, data: 4'h9});
      for (int c = 0; c < 1000 && n < 300; c++) begin
         @(negedge clk);
         if (fifo_wr_en) n++;
         if (n < 300) tick();
      end
      tick();
      req_valid = 4'b0000;
      checks++;
      if (n !== 300) begin
         failures++;
         $display("FAIL stats_beats_timeout got=%0d exp=%0d", n, 300);
      end
`ifdef FIFO_WR_ARB_STATS_EN
      tick();
      @(negedge clk);
      checks++;
      if (stat_count !== 8'd255) begin
         failures++;
         $display("FAIL stats_saturate got=%0d exp=%0d", stat_count, 255);
      end
      tick();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      @(negedge clk);
      checks++;
      if (stat_count !== 8'd0) begin
         failures++;
         $display("FAIL stats_clear got=%0d exp=%0d", stat_count, 0);
      end
      tick();
      @(negedge clk);
      checks++;
      if (stat_count !== 8'd0) begin
         failures++;
         $display("FAIL stats_clear_hold got=%0d exp=%0d", stat_count, 0);
      end
      stat_sel = 2'd2;
      tick();
      @(negedge clk);
      checks++;
      if (stat_count !== 8'd0) begin
         failures++;
         $display("FAIL stats_idle_req got=%0d exp=%0d", stat_count, 0);
      end
`else
      tick();
      @(negedge clk);
      checks++;
      if (stat_count !== 8'd0) begin
         failures++;
         $display("FAIL stats_disabled got=%0d exp=%0d", stat_count, 0);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_req();
      test_round_robin();
      test_full_stall();
      test_owner_drop();
      test_reset_mid_burst();
      test_stats();
      repeat (2) tick();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=%0d", exp_q.size(), 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
